// File: rtl/orao_tape_pkg.sv
// Shared types and WAV header constants for the Orao tape player.
package orao_tape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FILL,
    ST_PLAY,
    ST_DRAIN,
    ST_ERR
  } tape_state_t;

  localparam int unsigned HDR_LEN  = 44;
  localparam int unsigned RIFF_OFS = 0;
  localparam int unsigned WAVE_OFS = 8;
  localparam int unsigned RATE_OFS = 24;

  localparam logic [31:0] MAGIC_RIFF = "RIFF";
  localparam logic [31:0] MAGIC_WAVE = "WAVE";

  // Character idx of a four-character tag, first character in the top byte.
  function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
    return magic[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/orao_tape_player_if.sv
// ioctl download bus between hps_io (master) and the tape player (slave).
interface orao_tape_player_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait
  );
endinterface

// File: rtl/orao_tape_fifo.sv
// Single-clock sample FIFO on inferred block RAM with occupancy count.
module orao_tape_fifo #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a write on full is still taken.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
    if (do_pop)  dout <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/orao_tape_player.sv
// WAV tape loader: strips the header, buffers samples and replays them as a paced 1-bit level.
// Define ORAO_TAPE_HEADER_EN to build the RIFF/WAVE header parser; otherwise DEFAULT_RATE is used.
module orao_tape_player
  import orao_tape_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned FIFO_AW      = 10,
  parameter logic [7:0]  TAPE_INDEX   = 8'd1,
  parameter int unsigned DEFAULT_RATE = 22050,
  parameter logic [7:0]  THRESH       = 8'h80
) (
  input  logic              clk_sys,
  input  logic              reset,
  orao_tape_player_if.slave ioctl,
  output logic              tape_bit,
  output logic              tape_active,
  output logic              hdr_err,
  output logic              overflow
);
  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] HALF     = (FIFO_AW+1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0] WAIT_LVL = (FIFO_AW+1)'(DEPTH - 4);
  localparam logic [31:0]      CLK_W    = 32'(CLK_HZ);
`ifdef ORAO_TAPE_HEADER_EN
  localparam tape_state_t      START_ST = ST_HDR;
`else
  localparam tape_state_t      START_ST = ST_FILL;
`endif

  tape_state_t      state, state_nx;
  logic             dl_match, dl_q, start, accept;
  logic             push, pop, drop, full, empty, pop_d, wait_q, tick;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] count;
  logic [31:0]      acc, rate;

  assign dl_match    = ioctl.ioctl_download && (ioctl.ioctl_index == TAPE_INDEX);
  assign start       = dl_match && !dl_q;
  assign accept      = ioctl.ioctl_wr && dl_match;
  assign tick        = (acc >= CLK_W);
  assign drop        = push && full && !pop;
  assign tape_active = (state == ST_PLAY) || (state == ST_DRAIN);
  assign ioctl.ioctl_wait = wait_q;

`ifdef ORAO_TAPE_HEADER_EN
  logic        riff_ok, wave_ok, hdr_ok, hdr_err_q;
  logic [31:0] rate_q;
  logic [24:0] a;

  assign a       = ioctl.ioctl_addr;
  assign hdr_ok  = riff_ok && wave_ok && (rate_q != '0) && (rate_q < CLK_W);
  assign rate    = rate_q;
  assign hdr_err = hdr_err_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      riff_ok   <= 1'b0;
      wave_ok   <= 1'b0;
      rate_q    <= '0;
      hdr_err_q <= 1'b0;
    end else if (start) begin
      riff_ok   <= 1'b1;
      wave_ok   <= 1'b1;
      rate_q    <= '0;
      hdr_err_q <= 1'b0;
    end else if (state == ST_HDR && accept) begin
      if (a < 25'(RIFF_OFS + 4) && ioctl.ioctl_dout != magic_byte(MAGIC_RIFF, a[1:0]))
        riff_ok <= 1'b0;
      if (a >= 25'(WAVE_OFS) && a < 25'(WAVE_OFS + 4) &&
          ioctl.ioctl_dout != magic_byte(MAGIC_WAVE, a[1:0]))
        wave_ok <= 1'b0;
      // RATE_OFS is word aligned, so the low address bits select the byte lane.
      if (a >= 25'(RATE_OFS) && a < 25'(RATE_OFS + 4))
        rate_q[{a[1:0], 3'b000} +: 8] <= ioctl.ioctl_dout;
      if (a == 25'(HDR_LEN - 1) && !hdr_ok)
        hdr_err_q <= 1'b1;
    end
  end
`else
  assign rate    = 32'(DEFAULT_RATE);
  assign hdr_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    pop      = 1'b0;
    case (state)
      ST_IDLE: state_nx = ST_IDLE;
`ifdef ORAO_TAPE_HEADER_EN
      ST_HDR:
        if (accept && ioctl.ioctl_addr == 25'(HDR_LEN - 1))
          state_nx = hdr_ok ? ST_FILL : ST_ERR;
`endif
      ST_FILL: begin
        push = accept;
        if (count >= HALF || !ioctl.ioctl_download) state_nx = ST_PLAY;
      end
      ST_PLAY: begin
        push = accept;
        pop  = tick && !empty;
        if (!ioctl.ioctl_download) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        pop = tick && !empty;
        // Hold until the last popped sample has reached tape_bit.
        if (empty && !pop_d) state_nx = ST_IDLE;
      end
      ST_ERR:
        if (!ioctl.ioctl_download) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (start) state_nx = START_ST;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      dl_q     <= 1'b0;
      acc      <= '0;
      pop_d    <= 1'b0;
      wait_q   <= 1'b0;
      tape_bit <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nx;
      dl_q   <= dl_match;
      pop_d  <= pop;
      wait_q <= (count >= WAIT_LVL) && (state == ST_FILL || state == ST_PLAY);
      if (start)            acc <= '0;
      else if (tape_active) acc <= acc + rate - (tick ? CLK_W : '0);
      if (start)            overflow <= 1'b0;
      else if (drop)        overflow <= 1'b1;
      if (state_nx == ST_IDLE && state != ST_IDLE) tape_bit <= 1'b0;
      else if (pop_d)                              tape_bit <= (fifo_dout >= THRESH);
    end
  end

  orao_tape_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .clr   (start),
    .push  (push),
    .din   (ioctl.ioctl_dout),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_orao_tape_player.sv
// Directed bench for orao_tape_player with a scoreboard of expected tape_bit values.
module tb_orao_tape_player;
  import orao_tape_pkg::*;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned RATE    = 22050;
  localparam int unsigned PMIN    = CLK_HZ / RATE;
  localparam int unsigned PMAX    = PMIN + 1;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic tape_bit, tape_active, hdr_err, overflow;

  orao_tape_player_if bus ();

  orao_tape_player #(
    .CLK_HZ       (CLK_HZ),
    .FIFO_AW      (FIFO_AW),
    .TAPE_INDEX   (8'd1),
    .DEFAULT_RATE (RATE),
    .THRESH       (8'h80)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl       (bus),
    .tape_bit    (tape_bit),
    .tape_active (tape_active),
    .hdr_err     (hdr_err),
    .overflow    (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int          errors = 0;
  int          checks = 0;
  bit          exp_q[$];
  bit          sb_en = 0, chk_period = 0, have_toggle = 0;
  bit          wait_seen = 0, wait_prev = 0, watch_quiet = 0, quiet_bad = 0;
  logic        last_bit = 1'b0;
  int unsigned since_toggle = 0, period_sum = 0, period_n = 0;
  int unsigned prev_count = 0, wait_rise_count = 0, max_count = 0;
  int unsigned addr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every tape_bit change during playback is one replayed sample.
  always @(negedge clk_sys) begin
    if (!reset) begin
      since_toggle++;
      if (sb_en && tape_active && tape_bit !== last_bit) begin
        if (exp_q.size() == 0) check("extra_sample", 32'(tape_bit), 32'hx);
        else                   check("sample_bit", 32'(tape_bit), 32'(exp_q.pop_front()));
        if (chk_period && have_toggle) begin
          checks++;
          assert (since_toggle >= PMIN && since_toggle <= PMAX) else begin
            errors++;
            $error("FAIL period: observed=%0d expected=%0d..%0d", since_toggle, PMIN, PMAX);
          end
          period_sum += since_toggle;
          period_n++;
        end
        have_toggle  = 1;
        since_toggle = 0;
      end
    end
    last_bit = tape_bit;
    if (bus.ioctl_wait && !wait_prev && !wait_seen) begin
      wait_seen       = 1;
      wait_rise_count = prev_count;
    end
    wait_prev  = bus.ioctl_wait;
    prev_count = 32'(dut.u_fifo.count);
    if (prev_count > max_count) max_count = prev_count;
    if (watch_quiet && (tape_bit || tape_active || hdr_err || overflow || bus.ioctl_wait))
      quiet_bad = 1;
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    addr_cnt           = 0;
    cyc(2);
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    cyc(1);
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit honor_wait, input bit is_sample);
    int unsigned guard = 0;
    while (honor_wait && bus.ioctl_wait && guard < 2000) begin
      cyc(1);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $error("FAIL wait_timeout: observed=ioctl_wait stuck expected=release");
    end
    bus.ioctl_addr = 25'(addr_cnt);
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    if (is_sample) exp_q.push_back(d >= 8'h80);
    cyc(1);
    bus.ioctl_wr = 1'b0;
    addr_cnt++;
  endtask

  task automatic wait_idle();
    int unsigned g = 0;
    while (tape_active && g < 5000) begin
      cyc(1);
      g++;
    end
    if (g >= 5000) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed=tape_active stuck expected=0");
    end
    cyc(2);
  endtask

`ifdef ORAO_TAPE_HEADER_EN
  task automatic send_header(input logic [31:0] magic0, input logic [31:0] rate_v);
    logic [7:0]  h [44];
    logic [31:0] wave;
    wave = "WAVE";
    for (int i = 0; i < 44; i++) h[i] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      h[k]      = magic0[8*(3-k) +: 8];
      h[8 + k]  = wave[8*(3-k) +: 8];
      h[24 + k] = rate_v[8*k +: 8];
    end
    h[4] = 8'h24;
    for (int i = 0; i < 44; i++) wr_byte(h[i], 1'b1, 1'b0);
  endtask
`endif

  task automatic prelude();
`ifdef ORAO_TAPE_HEADER_EN
    send_header("RIFF", 32'(RATE));
`endif
  endtask

  task automatic new_sb(input bit period);
    exp_q.delete();
    sb_en        = 1;
    chk_period   = period;
    have_toggle  = 0;
    since_toggle = 0;
    period_sum   = 0;
    period_n     = 0;
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint diff;
    logic [7:0] d;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    cyc(3);
    check("rst_tape_bit", 32'(tape_bit), 0);
    check("rst_active", 32'(tape_active), 0);
    check("rst_hdr_err", 32'(hdr_err), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_wait", 32'(bus.ioctl_wait), 0);
    check("rst_count", 32'(dut.u_fifo.count), 0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0;
    cyc(2);

    // Alternating full-scale samples: paced toggles at the sample rate.
    new_sb(1);
    start_dl(8'd1);
    prelude();
    for (int i = 0; i < 60; i++) wr_byte((i % 2 == 0) ? 8'hFF : 8'h00, 1'b1, 1'b1);
    end_dl();
    wait_idle();
    check("play_all", exp_q.size(), 0);
    check("period_count", period_n, 59);
    diff = longint'(period_sum) * RATE - longint'(period_n) * CLK_HZ;
    if (diff < 0) diff = -diff;
    checks++;
    assert (diff <= longint'(RATE)) else begin
      errors++;
      $error("FAIL period_avg: observed=%0d cycles over %0d expected=%0d*%0d/%0d +-1",
             period_sum, period_n, period_n, CLK_HZ, RATE);
    end
    check("play_end_active", 32'(tape_active), 0);
    check("play_end_bit", 32'(tape_bit), 0);
    check("play_end_state", 32'(dut.state), 32'(ST_IDLE));
    check("play_overflow", 32'(overflow), 0);

    // Continuous stream honouring ioctl_wait, samples straddling the threshold.
    new_sb(1);
    wait_seen = 0;
    max_count = 0;
    start_dl(8'd1);
    prelude();
    for (int i = 0; i < 100; i++) begin
      if (i == 0)          d = 8'h80;
      else if (i == 1)     d = 8'h7F;
      else if (i % 2 == 0) d = 8'h80 | 8'($urandom_range(0, 127));
      else                 d = 8'($urandom_range(0, 127));
      wr_byte(d, 1'b1, 1'b1);
    end
    end_dl();
    wait_idle();
    check("wait_seen", 32'(wait_seen), 1);
    check("wait_at_count", wait_rise_count, DEPTH - 4);
    check("stream_max_le_depth", 32'(max_count <= DEPTH), 1);
    check("stream_overflow", 32'(overflow), 0);
    check("stream_all", exp_q.size(), 0);
    check("stream_periods", period_n, 99);

    // Ignore back-pressure: FIFO fills before the first pacing tick.
    sb_en = 0;
    start_dl(8'd1);
    prelude();
    for (int i = 0; i < 40; i++) wr_byte(8'hFF, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(dut.u_fifo.count), DEPTH);
    // Restart while still downloading clears the sticky flag.
    bus.ioctl_index = 8'd0;
    cyc(1);
    start_dl(8'd1);
    check("restart_ovf_clr", 32'(overflow), 0);
    check("restart_count", 32'(dut.u_fifo.count), 0);
    prelude();
    for (int i = 0; i < 20; i++) wr_byte((i % 2 == 0) ? 8'hFF : 8'h00, 1'b1, 1'b0);
    cyc(100);
    check("mid_play_active", 32'(tape_active), 1);
    reset = 1'b1;
    cyc(1);
    check("midrst_bit", 32'(tape_bit), 0);
    check("midrst_active", 32'(tape_active), 0);
    check("midrst_wait", 32'(bus.ioctl_wait), 0);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
    check("midrst_count", 32'(dut.u_fifo.count), 0);
    reset = 1'b0;
    bus.ioctl_download = 1'b0;
    cyc(2);
    new_sb(0);
    start_dl(8'd1);
    prelude();
    for (int i = 0; i < 20; i++)
      wr_byte((i % 2 == 0) ? (8'h80 | 8'($urandom_range(0, 127))) : 8'($urandom_range(0, 127)),
              1'b1, 1'b1);
    end_dl();
    wait_idle();
    check("fresh_all", exp_q.size(), 0);
    check("fresh_state", 32'(dut.state), 32'(ST_IDLE));

    // Download for another target is ignored entirely.
    sb_en       = 0;
    quiet_bad   = 0;
    watch_quiet = 1;
    start_dl(8'd0);
    for (int i = 0; i < 20; i++) wr_byte(8'hFF, 1'b1, 1'b0);
    end_dl();
    cyc(200);
    watch_quiet = 0;
    check("idx0_quiet", 32'(quiet_bad), 0);
    check("idx0_count", 32'(dut.u_fifo.count), 0);
    check("idx0_state", 32'(dut.state), 32'(ST_IDLE));

`ifdef ORAO_TAPE_HEADER_EN
    // Bad magic is rejected at the last header byte.
    quiet_bad = 0;
    start_dl(8'd1);
    send_header("RIFX", 32'(RATE));
    check("hdr_err_set", 32'(hdr_err), 1);
    check("hdr_err_state", 32'(dut.state), 32'(ST_ERR));
    for (int i = 0; i < 10; i++) wr_byte(8'hFF, 1'b1, 1'b0);
    check("hdr_err_bit", 32'(tape_bit), 0);
    check("hdr_err_active", 32'(tape_active), 0);
    check("hdr_err_count", 32'(dut.u_fifo.count), 0);
    end_dl();
    cyc(2);
    check("hdr_err_idle", 32'(dut.state), 32'(ST_IDLE));
    check("hdr_err_sticky", 32'(hdr_err), 1);
    start_dl(8'd1);
    check("hdr_err_clr", 32'(hdr_err), 0);
    end_dl();
    cyc(4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
